// File: rtl/fifo_spi_responder.sv
// Drains 24-bit ADC words from syn_fifo through a one-word prefetch register
// and serves them to the host MCU as a mode-0 SPI slave, MSB first.
//
// Prefetch FSM
//   state   | meaning
//   P_EMPTY | nothing held; issue a read as soon as the FIFO has data
//   P_READ  | read issued; FIFO data is valid this cycle and is latched
//   P_VALID | word held in the prefetch register, data_ready high
//
// Frame FSM
//   state   | meaning
//   F_IDLE  | CS high; wait for a synced CS fall to load the shift register
//   F_SHIFT | frame in progress; count SCK rises, shift on SCK falls
//   F_DONE  | full frame sent; extra SCK edges shift out zeros
module fifo_spi_responder #(
    parameter int                    DATA_WIDTH    = 24,
    parameter logic [DATA_WIDTH-1:0] EMPTY_PATTERN = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  host_cs_n,
    input  logic                  host_sck,
    output logic                  host_miso,
    output logic                  data_ready,
    output logic                  word_sent,
    output logic                  frame_error,
    output logic                  underrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {P_EMPTY, P_READ, P_VALID} pstate_t;
    typedef enum logic [1:0] {F_IDLE, F_SHIFT, F_DONE} fstate_t;

    pstate_t               p_state, p_next;
    fstate_t               f_state, f_next;
    logic [2:0]            cs_pipe, sck_pipe;
    logic                  cs_sync, cs_fall, cs_rise, sck_rise, sck_fall;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] shreg, shreg_next;
    logic [CW-1:0]         cnt, cnt_next, cnt_inc;
    logic                  consume;

    // Stages [1:0] synchronise the pins; stage [2] is the previous synced value.
    // CS resets to its idle-high level so reset release never looks like a CS fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_pipe  <= 3'b111;
            sck_pipe <= 3'b000;
        end else begin
            cs_pipe  <= {cs_pipe[1:0], host_cs_n};
            sck_pipe <= {sck_pipe[1:0], host_sck};
        end
    end

    assign cs_sync  = cs_pipe[1];
    assign cs_fall  = cs_pipe[2] & ~cs_pipe[1];
    assign cs_rise  = ~cs_pipe[2] & cs_pipe[1];
    assign sck_rise = ~sck_pipe[2] & sck_pipe[1];
    assign sck_fall = sck_pipe[2] & ~sck_pipe[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state  <= P_EMPTY;
            f_state  <= F_IDLE;
            hold_reg <= '0;
            shreg    <= '0;
            cnt      <= '0;
        end else begin
            p_state <= p_next;
            f_state <= f_next;
            shreg   <= shreg_next;
            cnt     <= cnt_next;
            if (p_state == P_READ) begin
                hold_reg <= fifo_data_out;
            end
        end
    end

    // Read strobe is gated by rst so no FIFO read can slip out while in reset.
    always_comb begin
        p_next     = p_state;
        fifo_rd_en = 1'b0;
        case (p_state)
            P_EMPTY: begin
                if (!fifo_empty && !rst) begin
                    fifo_rd_en = 1'b1;
                    p_next     = P_READ;
                end
            end
            P_READ:  p_next = P_VALID;
            P_VALID: begin
                if (consume) begin
                    p_next = P_EMPTY;
                end
            end
            default: p_next = P_EMPTY;
        endcase
    end

    assign data_ready = (p_state == P_VALID);
    assign cnt_inc    = cnt + 1'b1;

    always_comb begin
        f_next      = f_state;
        shreg_next  = shreg;
        cnt_next    = cnt;
        consume     = 1'b0;
        word_sent   = 1'b0;
        frame_error = 1'b0;
        underrun    = 1'b0;
        case (f_state)
            F_IDLE: begin
                if (cs_fall) begin
                    // A word still in P_READ counts as not held and waits for the next frame.
                    if (p_state == P_VALID) begin
                        shreg_next = hold_reg;
                        consume    = 1'b1;
                    end else begin
                        shreg_next = EMPTY_PATTERN;
                        underrun   = 1'b1;
                    end
                    cnt_next = '0;
                    f_next   = F_SHIFT;
                end
            end
            F_SHIFT: begin
                if (cs_rise) begin
                    frame_error = 1'b1;
                    f_next      = F_IDLE;
                end else if (sck_rise) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == CW'(DATA_WIDTH)) begin
                        word_sent = 1'b1;
                        f_next    = F_DONE;
                    end
                end else if (sck_fall) begin
                    shreg_next = {shreg[DATA_WIDTH-2:0], 1'b0};
                end
            end
            F_DONE: begin
                if (cs_rise) begin
                    f_next = F_IDLE;
                end else if (sck_fall) begin
                    shreg_next = {shreg[DATA_WIDTH-2:0], 1'b0};
                end
            end
            default: f_next = F_IDLE;
        endcase
    end

    assign host_miso = ~cs_sync & shreg[DATA_WIDTH-1];

endmodule

// File: tb/tb_fifo_spi_responder.sv
// Self-checking bench for fifo_spi_responder: a queue-based FIFO model feeds the
// DUT, a word-level model predicts each frame, and a monitor checks every cycle.
module tb_fifo_spi_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] fifo_data_out = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic        host_cs_n = 1'b1;
    logic        host_sck = 1'b0;
    logic        host_miso, data_ready, word_sent, frame_error, underrun;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rd = 0, n_ws = 0, n_fe = 0, n_ur = 0;
    int frame_rises = 0;
    int cs_high_cnt = 0;
    int dr_low = 0;
    bit seen_dr = 0;
    bit dr_prev = 0;

    logic [23:0] fifo_q[$];
    logic [23:0] exp_q[$];

    fifo_spi_responder dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_data_out(fifo_data_out),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .host_cs_n    (host_cs_n),
        .host_sck     (host_sck),
        .host_miso    (host_miso),
        .data_ready   (data_ready),
        .word_sent    (word_sent),
        .frame_error  (frame_error),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // syn_fifo model: read data valid the cycle after the strobe
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_data_out <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (host_cs_n) cs_high_cnt++; else cs_high_cnt = 0;
        if (!rst) begin
            check("rd_while_empty", {31'b0, fifo_rd_en & fifo_empty}, 32'd0);
            if (cs_high_cnt >= 4) check("miso_idle", {31'b0, host_miso}, 32'd0);
            if (fifo_rd_en) n_rd++;
            if (frame_error) n_fe++;
            if (underrun) n_ur++;
            if (word_sent) begin
                n_ws++;
                check("ws_at_24th_rise", frame_rises, 32'd24);
            end
            if (data_ready && !dr_prev && seen_dr) check("dr_gap_ge2", {31'b0, dr_low >= 2}, 32'd1);
            if (data_ready) begin
                seen_dr = 1;
                dr_low  = 0;
            end else begin
                dr_low++;
            end
            dr_prev = data_ready;
        end else begin
            seen_dr = 0;
            dr_prev = 0;
        end
    end

    task automatic push_word(input logic [23:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, {31'b0, fifo_rd_en}, 32'd0);
        check({tag, "_miso"}, {31'b0, host_miso}, 32'd0);
        check({tag, "_data_ready"}, {31'b0, data_ready}, 32'd0);
        check({tag, "_word_sent"}, {31'b0, word_sent}, 32'd0);
        check({tag, "_frame_error"}, {31'b0, frame_error}, 32'd0);
        check({tag, "_underrun"}, {31'b0, underrun}, 32'd0);
    endtask

    // Host side: miso is sampled just before each SCK rise, as a mode-0 master would.
    task automatic run_frame(input int nb, input bit rst_mid,
                             output logic [23:0] got, output logic [7:0] extra);
        got = '0;
        extra = '0;
        frame_rises = 0;
        host_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            int hp;
            hp = $urandom_range(4, 6);
            if (i < 24) got[23-i] = host_miso; else extra[i-24] = host_miso;
            host_sck = 1'b1;
            frame_rises++;
            repeat (hp) @(negedge clk);
            host_sck = 1'b0;
            repeat (hp) @(negedge clk);
        end
        if (rst_mid) begin
            #1 rst = 1'b1;
            #2 check_outputs_zero("mid_rst");
            host_cs_n = 1'b1;
            host_sck  = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            host_cs_n = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    // Word-level model: frames take words in push order; no held word means the
    // empty pattern plus an underrun; an aborted frame still consumes its word.
    task automatic do_frame(input int nb, output logic [23:0] got);
        logic [23:0] exp;
        logic [7:0]  extra;
        logic [23:0] diff;
        bit          has;
        int ws0, fe0, ur0;
        ws0 = n_ws; fe0 = n_fe; ur0 = n_ur;
        has = (exp_q.size() > 0);
        check("dr_before_frame", {31'b0, data_ready}, {31'b0, has});
        exp = has ? exp_q.pop_front() : 24'hFFFFFF;
        run_frame(nb, 1'b0, got, extra);
        check("underrun_cnt", n_ur - ur0, {31'b0, !has});
        if (nb >= 24) begin
            check("frame_word", {8'b0, got}, {8'b0, exp});
            check("extra_bits_zero", {24'b0, extra & 8'((1 << (nb - 24)) - 1)}, 32'd0);
            check("word_sent_cnt", n_ws - ws0, 32'd1);
            check("frame_error_cnt", n_fe - fe0, 32'd0);
        end else begin
            diff = got ^ exp;
            if (nb > 0) check("partial_prefix", {8'b0, diff >> (24 - nb)}, 32'd0);
            check("word_sent_cnt", n_ws - ws0, 32'd0);
            check("frame_error_cnt", n_fe - fe0, 32'd1);
        end
    endtask

    initial begin
        logic [23:0] got;
        logic [7:0]  extra;
        int rd0, ur0, fe0, ws0;
        bit seen;

        #1 rst = 1'b1;
        #2 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single word, fetch latency
        rd0 = n_rd;
        push_word(24'hA5C3F0);
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (data_ready) seen = 1;
        end
        check("dr_within_bound", {31'b0, seen}, 32'd1);
        check("rd_pulse_once", n_rd - rd0, 32'd1);
        do_frame(24, got);
        check("lit_A5C3F0", {8'b0, got}, 32'h00A5C3F0);
        check("dr_after_empty", {31'b0, data_ready}, 32'd0);

        // three back-to-back words
        rd0 = n_rd; ur0 = n_ur;
        push_word(24'h000001);
        push_word(24'h800000);
        push_word(24'h123456);
        repeat (8) @(negedge clk);
        do_frame(24, got);
        check("lit_000001", {8'b0, got}, 32'h00000001);
        do_frame(24, got);
        check("lit_800000", {8'b0, got}, 32'h00800000);
        do_frame(24, got);
        check("lit_123456", {8'b0, got}, 32'h00123456);
        check("three_reads", n_rd - rd0, 32'd3);
        check("no_underrun", n_ur - ur0, 32'd0);

        // empty FIFO
        rd0 = n_rd;
        do_frame(24, got);
        check("lit_empty_pattern", {8'b0, got}, 32'h00FFFFFF);
        check("no_read_when_empty", n_rd - rd0, 32'd0);

        // aborted frame, then the next word intact
        push_word(24'hDEADBE);
        repeat (8) @(negedge clk);
        do_frame(10, got);
        push_word(24'h0F0F0F);
        repeat (8) @(negedge clk);
        do_frame(24, got);
        check("lit_0F0F0F", {8'b0, got}, 32'h000F0F0F);

        // overlong frame
        push_word(24'hFFFFFF);
        repeat (8) @(negedge clk);
        ws0 = n_ws;
        do_frame(30, got);
        check("overlong_one_ws", n_ws - ws0, 32'd1);

        // async reset mid-frame: held refill word is lost, FIFO contents kept
        push_word(24'h111111);
        push_word(24'h222222);
        repeat (8) @(negedge clk);
        void'(exp_q.pop_front());
        fe0 = n_fe; ws0 = n_ws;
        run_frame(12, 1'b1, got, extra);
        check("rst_prefix", {20'b0, got[23:12]}, 32'h111);
        check("rst_no_ws", n_ws - ws0, 32'd0);
        exp_q = fifo_q;
        push_word(24'h333333);
        repeat (8) @(negedge clk);
        do_frame(24, got);
        check("lit_after_rst", {8'b0, got}, 32'h00333333);
        check("fe_during_rst", n_fe - fe0, 32'd0);

        // randomized frames
        for (int f = 0; f < 24; f++) begin
            int np, kind, nb;
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) push_word(24'($urandom));
            repeat (8) @(negedge clk);
            kind = $urandom_range(0, 9);
            if (kind < 6) nb = 24;
            else if (kind < 8) nb = $urandom_range(0, 23);
            else nb = $urandom_range(25, 28);
            do_frame(nb, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
